// File: rtl/spectral_bin_remapper.sv
// rtl/spectral_bin_remapper.sv - per-frame pitch-ratio spectral bin remapper feeding the IFFT
// Walks output bins, derives Hermitian-mirrored source bins, reads spectrum RAM, streams with backpressure.
module spectral_bin_remapper #(
    parameter int FFT_LOG2   = 10,
    parameter int DATA_W     = 32,
    parameter int RATIO_W    = 12,
    parameter int RATIO_FRAC = 8,
    parameter int RAM_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [RATIO_W-1:0]  ratio,
    output logic                busy,
    output logic                ram_rd_en,
    output logic [FFT_LOG2-1:0] ram_addr,
    input  logic [DATA_W-1:0]   ram_data,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic                frame_done
);
    localparam int N      = 1 << FFT_LOG2;
    localparam int DEPTH  = RAM_LAT + 2;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PROD_W = FFT_LOG2 + RATIO_W;
    localparam int S_W    = PROD_W - RATIO_FRAC;
    localparam logic [FFT_LOG2-1:0] K_HALF     = FFT_LOG2'(N / 2);
    localparam logic [S_W-1:0]      S_HALF     = S_W'(N / 2);
    localparam logic [1:0]          MODE_REMAP = 2'b01;
    localparam logic [1:0]          MODE_MUTE  = 2'b10;

    logic                r_busy, r_active, r_frame_done;
    logic [FFT_LOG2-1:0] r_k;
    logic [1:0]          r_mode;
    logic [RATIO_W-1:0]  r_ratio;
    logic                r_s1_valid, r_s1_upper;
    logic [FFT_LOG2-1:0] r_s1_k;
    logic [1:0]          r_s1_mode;
    logic [S_W-1:0]      r_s1_s;
    logic                r_ram_rd_en;
    logic [FFT_LOG2-1:0] r_ram_addr;
    logic                r_s2_valid, r_s2_zero, r_s2_last;
    logic [RAM_LAT-1:0]  r_dl_valid, r_dl_zero, r_dl_last;
    logic [DATA_W-1:0]   r_mem_data [DEPTH];
    logic                r_mem_last [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_start_acc, w_upper, w_pop, w_credit, w_adv, w_issue;
    logic                w_zero, w_fifo_wr;
    logic [FFT_LOG2-1:0] w_cur_k, w_mult_x, w_src;
    logic [1:0]          w_cur_mode;
    logic [RATIO_W-1:0]  w_cur_ratio;
    logic [S_W-1:0]      w_s;
    logic [DATA_W-1:0]   w_fifo_data;
    int                  w_inflight;

    // The start cycle issues bin 0 directly from the live mode/ratio inputs.
    assign w_start_acc = start & ~r_busy;
    assign w_cur_k     = w_start_acc ? '0 : r_k;
    assign w_cur_mode  = w_start_acc ? mode : r_mode;
    assign w_cur_ratio = w_start_acc ? ratio : r_ratio;
    assign w_upper     = w_cur_k > K_HALF;
    assign w_mult_x    = w_upper ? ('0 - w_cur_k) : w_cur_k;
    assign w_s         = S_W'((PROD_W'(w_mult_x) * PROD_W'(w_cur_ratio)) >> RATIO_FRAC);

    // A RAM read cannot be stalled once issued, so credit covers stage 2, the latency line and the FIFO.
    assign w_pop      = m_valid & m_ready;
    assign w_inflight = int'(r_s2_valid) + $countones(r_dl_valid);
    assign w_credit   = (int'(r_count) + w_inflight - int'(w_pop)) < DEPTH;
    assign w_adv      = r_s1_valid & w_credit;
    assign w_issue    = (w_start_acc | r_active) & (~r_s1_valid | w_adv);

    always_comb begin
        w_zero = 1'b0;
        w_src  = r_s1_k;
        case (r_s1_mode)
            MODE_MUTE: w_zero = 1'b1;
            MODE_REMAP: begin
                if (!r_s1_upper) begin
                    w_zero = r_s1_s > S_HALF;
                    w_src  = r_s1_s[FFT_LOG2-1:0];
                end else begin
                    w_zero = r_s1_s >= S_HALF;
                    w_src  = (r_s1_s == '0) ? '0 : ('0 - r_s1_s[FFT_LOG2-1:0]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy       <= 1'b0;
            r_active     <= 1'b0;
            r_frame_done <= 1'b0;
            r_k          <= '0;
            r_mode       <= '0;
            r_ratio      <= '0;
        end else begin
            r_frame_done <= w_pop & m_last;
            if (w_start_acc) begin
                r_busy  <= 1'b1;
                r_mode  <= mode;
                r_ratio <= ratio;
            end else if (w_pop & m_last) begin
                r_busy <= 1'b0;
            end
            if (w_issue) begin
                r_k      <= w_cur_k + 1'b1;
                r_active <= (w_cur_k != '1);
            end else if (w_start_acc) begin
                r_k      <= '0;
                r_active <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_upper  <= 1'b0;
            r_s1_k      <= '0;
            r_s1_mode   <= '0;
            r_s1_s      <= '0;
            r_ram_rd_en <= 1'b0;
            r_ram_addr  <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_last   <= 1'b0;
            r_dl_valid  <= '0;
            r_dl_zero   <= '0;
            r_dl_last   <= '0;
        end else begin
            if (w_issue) begin
                r_s1_valid <= 1'b1;
                r_s1_upper <= w_upper;
                r_s1_k     <= w_cur_k;
                r_s1_mode  <= w_cur_mode;
                r_s1_s     <= w_s;
            end else if (w_adv) begin
                r_s1_valid <= 1'b0;
            end
            r_ram_rd_en <= w_adv & ~w_zero;
            if (w_adv) r_ram_addr <= w_src;
            r_s2_valid <= w_adv;
            r_s2_zero  <= w_zero;
            r_s2_last  <= (r_s1_k == '1);
            r_dl_valid <= (r_dl_valid << 1) | RAM_LAT'(r_s2_valid);
            r_dl_zero  <= (r_dl_zero << 1) | RAM_LAT'(r_s2_zero);
            r_dl_last  <= (r_dl_last << 1) | RAM_LAT'(r_s2_last);
        end
    end

    // Zero bins keep their slot and enter the FIFO as literal zeros.
    assign w_fifo_wr   = r_dl_valid[RAM_LAT-1];
    assign w_fifo_data = r_dl_zero[RAM_LAT-1] ? '0 : ram_data;

    always_ff @(posedge clk) begin
        if (w_fifo_wr) begin
            r_mem_data[r_wr_ptr] <= w_fifo_data;
            r_mem_last[r_wr_ptr] <= r_dl_last[RAM_LAT-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fifo_wr) r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + CNT_W'(w_fifo_wr) - CNT_W'(w_pop);
        end
    end

    assign busy       = r_busy;
    assign ram_rd_en  = r_ram_rd_en;
    assign ram_addr   = r_ram_addr;
    assign m_valid    = (r_count != '0);
    assign m_data     = m_valid ? r_mem_data[r_rd_ptr] : '0;
    assign m_last     = m_valid & r_mem_last[r_rd_ptr];
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_spectral_bin_remapper.sv
// tb/tb_spectral_bin_remapper.sv - scoreboard bench for spectral_bin_remapper with N=16, RAM_LAT=1
module tb_spectral_bin_remapper;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [11:0] ratio = '0;
    logic        busy, ram_rd_en, m_valid, m_last, frame_done;
    logic [3:0]  ram_addr;
    logic [31:0] ram_data = '0;
    logic [31:0] m_data;
    logic        m_ready = 1'b1;

    int n_checks = 0, n_pass = 0;
    int exp_q[$];
    bit last_q[$];
    int got[N];
    int beat_idx = 0, frames_done = 0, cur_frame = 0;
    int rd_total = 0, rd_base = 0, exp_reads = 0;
    bit rand_ready = 0, overflow_seen = 0;
    bit prev_stall = 0, fd_pending = 0, prev_last = 0;
    logic [31:0] prev_data = '0;

    spectral_bin_remapper #(.FFT_LOG2(4), .DATA_W(32), .RATIO_W(12), .RATIO_FRAC(8), .RAM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ratio(ratio), .busy(busy),
        .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_data(ram_data), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_rd_en) ram_data <= 32'(100 + int'(ram_addr));
    always @(posedge clk) if (rst_n && ram_rd_en) rd_total <= rd_total + 1;
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int ref_bin(input int k, input int md, input int rt);
        int s;
        if (md == 2) return 0;
        if (md != 1) return 100 + k;
        if (k <= N / 2) begin
            s = (k * rt) / 256;
            return (s > N / 2) ? 0 : 100 + s;
        end
        s = ((N - k) * rt) / 256;
        if (s >= N / 2) return 0;
        if (s == 0) return 100;
        return 100 + N - s;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            fd_pending = 0;
        end else begin
            if (dut.w_fifo_wr && dut.r_count == 3 && !(m_valid && m_ready)) overflow_seen = 1;
            if (fd_pending) begin
                check("frame_done_pulse", frame_done, 1);
                check("busy_fall", busy, 0);
                fd_pending = 0;
                frames_done++;
            end else begin
                check("frame_done_idle", frame_done, 0);
            end
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_data, -1);
                end else begin
                    check("beat_data", m_data, exp_q.pop_front());
                    check("beat_last", m_last, last_q.pop_front());
                end
                if (beat_idx < N) got[beat_idx] = int'(m_data);
                beat_idx++;
                if (m_last) fd_pending = 1;
            end
        end
    end

    task automatic start_frame(input int md, input int rt);
        mode  = 2'(md);
        ratio = 12'(rt);
        start = 1'b1;
        beat_idx  = 0;
        exp_reads = 0;
        rd_base   = rd_total;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(ref_bin(k, md, rt));
            last_q.push_back(k == N - 1);
            if (ref_bin(k, md, rt) != 0) exp_reads++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        cur_frame = frames_done;
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (frames_done > cur_frame) begin ok = 1; break; end
        end
        check({name, "_completed"}, ok, 1);
        check({name, "_beats"}, beat_idx, N);
        check({name, "_ram_reads"}, rd_total - rd_base, exp_reads);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, busy, 0);
        check({name, "_m_valid"}, m_valid, 0);
        check({name, "_m_data"}, m_data, 0);
        check({name, "_m_last"}, m_last, 0);
        check({name, "_frame_done"}, frame_done, 0);
        check({name, "_ram_rd_en"}, ram_rd_en, 0);
        check({name, "_ram_addr"}, ram_addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");

        @(posedge clk); #1;
        start_frame(0, 0);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (m_valid) begin lat = c; break; end
        end
        check("first_valid_latency", lat, 4);
        wait_done("bypass");
        for (int k = 0; k < N; k += 5) check("bypass_bin", got[k], 100 + k);

        start_frame(1, 512);
        wait_done("remap_x2");
        check("x2_k3", got[3], 106);
        check("x2_k5", got[5], 0);
        check("x2_k8", got[8], 0);
        check("x2_k13", got[13], 110);
        check("x2_k0", got[0], 100);

        start_frame(1, 128);
        wait_done("remap_x05");
        check("x05_k3", got[3], 101);
        check("x05_k8", got[8], 104);
        check("x05_k15", got[15], 100);
        check("x05_k9", got[9], 113);

        rand_ready = 1;
        start_frame(1, 512);
        wait_done("remap_x2_stall");
        check("stall_k3", got[3], 106);
        check("stall_k13", got[13], 110);
        for (int f = 0; f < 6; f++) begin
            start_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
            wait_done("random_frame");
        end
        start_frame(2, 300);
        wait_done("mute");
        rand_ready = 0;
        @(posedge clk); #1;

        start_frame(1, 128);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; mode = 2'b10; ratio = 12'd999;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 start = 1'b1; mode = 2'b00; ratio = 12'd77;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (frame_done) begin lat = 1; break; end
        end
        check("ignored_start_frame_done_seen", lat, 1);
        check("ignored_start_beats", beat_idx, N);
        start_frame(1, 384);
        wait_done("start_at_done");

        start_frame(0, 0);
        lat = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (beat_idx >= 7) begin lat = 1; break; end
        end
        check("reached_beat7", lat, 1);
        rst_n = 1'b0;
        exp_q.delete();
        last_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        @(posedge clk); #1;
        start_frame(0, 0);
        wait_done("post_reset");

        repeat (20) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("no_extra_beats", beat_idx, N);
        check("fifo_overflow", overflow_seen, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
